// File: rtl/mem_dump_ctrl.sv
// rtl/mem_dump_ctrl.sv - end-of-run halt, data-memory dump streamer and run watchdog
module mem_dump_ctrl #(
    parameter int DEPTH          = 512,
    parameter int ADDR_W         = 9,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 300
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              finish_i,
    output logic              halt_o,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_index_o,
    output logic              out_last_o,
    output logic              done_o,
    output logic              timeout_o
);

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4,
        S_TIMEOUT = 3'd5
    } state_t;

    localparam logic [15:0]       LP_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LP_IDX_LAST = ADDR_W'(DEPTH - 1);

    state_t              r_state;
    state_t              w_next;
    logic [15:0]         r_cnt;
    logic [ADDR_W-1:0]   r_idx;
    logic [DATA_W-1:0]   r_data;
    logic                r_halt;
    logic                r_done;
    logic                r_timeout;
    logic                w_valid;
    logic                w_hs;
    logic                w_idx_last;
    logic                w_cnt_last;

    assign w_idx_last = (r_idx == LP_IDX_LAST);
    assign w_cnt_last = (r_cnt == LP_CNT_LAST);
    assign w_hs       = w_valid & out_ready_i;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; finish takes priority over a watchdog expiry on the same edge
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RUN: begin
                if (finish_i) begin
                    w_next = S_ISSUE;
                end else if (w_cnt_last) begin
                    w_next = S_TIMEOUT;
                end
            end
            S_ISSUE:   w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_PRESENT;
            S_PRESENT: begin
                if (w_hs) begin
                    w_next = w_idx_last ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:    w_next = S_DONE;
            S_TIMEOUT: w_next = S_TIMEOUT;
            default:   w_next = S_RUN;
        endcase
    end

    // Datapath: watchdog counter, word index, captured word and sticky status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_data    <= '0;
            r_halt    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == S_RUN) begin
                r_cnt <= r_cnt + 16'd1;
                if (finish_i) begin
                    r_idx  <= '0;
                    r_halt <= 1'b1;
                end else if (w_cnt_last) begin
                    r_halt    <= 1'b1;
                    r_timeout <= 1'b1;
                end
            end
            if (r_state == S_CAPTURE) begin
                r_data <= mem_rdata_i;
            end
            if ((r_state == S_PRESENT) && w_hs) begin
                if (w_idx_last) begin
                    r_done <= 1'b1;
                end else begin
                    r_idx <= r_idx + ADDR_W'(1);
                end
            end
        end
    end

    // Output decode from registered state and datapath
    always_comb begin
        mem_rd_o    = (r_state == S_ISSUE);
        w_valid     = (r_state == S_PRESENT);
        out_valid_o = w_valid;
        out_last_o  = w_valid & w_idx_last;
        mem_addr_o  = r_idx;
        out_index_o = r_idx;
        out_data_o  = r_data;
        halt_o      = r_halt;
        done_o      = r_done;
        timeout_o   = r_timeout;
    end

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// tb/tb_mem_dump_ctrl.sv - scoreboard bench for mem_dump_ctrl
module tb_mem_dump_ctrl;

    localparam int DEPTH   = 512;
    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 300;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              finish_i = 1'b0;
    logic              halt_o;
    logic              mem_rd_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_rdata_i = '0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b1;
    logic [DATA_W-1:0] out_data_o;
    logic [ADDR_W-1:0] out_index_o;
    logic              out_last_o;
    logic              done_o;
    logic              timeout_o;

    mem_dump_ctrl #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .finish_i(finish_i), .halt_o(halt_o),
        .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_index_o(out_index_o), .out_last_o(out_last_o), .done_o(done_o),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } word_t;

    logic [DATA_W-1:0] mem [DEPTH];
    word_t             exp_q[$];
    int                errors = 0;
    int                checks = 0;
    int                rd_count = 0;
    int                cyc = 0;
    int                cyc0 = 0;
    int                fin_edge = 0;
    bit                bp_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // one-cycle synchronous data memory
    always @(posedge clk) if (mem_rd_o) mem_rdata_i <= mem[mem_addr_o];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // consumer ready: always high, or 30% high under backpressure
    initial forever begin
        @(posedge clk);
        #1;
        out_ready_i = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    // monitor: read-address order and word stream against the scoreboard queue
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (mem_rd_o) begin
                check("rd_addr", 64'(mem_addr_o), 64'(rd_count));
                rd_count++;
            end
            if (out_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 64'(out_valid_o), 64'd0);
                end else begin
                    check("word_index", 64'(out_index_o), 64'(exp_q[0].idx));
                    check("word_data", 64'(out_data_o), 64'(exp_q[0].data));
                    check("word_last", 64'(out_last_o), 64'(exp_q[0].idx == DEPTH - 1));
                    if (out_ready_i) void'(exp_q.pop_front());
                end
            end else begin
                check("last_without_valid", 64'(out_last_o), 64'd0);
            end
        end
    end

    task automatic do_reset(input bit random_mem);
        @(negedge clk);
        #2 rst_n = 1'b0;
        finish_i = 1'b0;
        #1;
        check("async_reset_outputs",
              {halt_o, mem_rd_o, out_valid_o, out_last_o, done_o, timeout_o,
               mem_addr_o, out_index_o, out_data_o}, '0);
        exp_q.delete();
        rd_count = 0;
        for (int i = 0; i < DEPTH; i++)
            mem[i] = random_mem ? $urandom() : (32'hA500_0000 + 32'(i));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc0 = cyc;
    endtask

    // raise finish so that it is sampled at edge n after reset release
    task automatic pulse_finish(input int n);
        while ((cyc - cyc0) < n - 1) @(negedge clk);
        check("halt_before_finish", 64'(halt_o), 64'd0);
        finish_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) exp_q.push_back('{idx: i, data: mem[i]});
        fin_edge = cyc + 1;
        @(negedge clk);
        finish_i = 1'b0;
        check("halt_after_finish", 64'(halt_o), 64'd1);
        check("first_read_follows", 64'(mem_rd_o), 64'd1);
    endtask

    task automatic wait_done(input bit check_time, input bit toggle_finish);
        int n = 0;
        while (!done_o && n < 8000) begin
            @(negedge clk);
            if (toggle_finish) finish_i = $urandom_range(0, 1);
            n++;
        end
        finish_i = 1'b0;
        check("done_reached", 64'(done_o), 64'd1);
        if (done_o && check_time)
            check("done_latency", 64'(cyc - fin_edge), 64'(3 * DEPTH));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("read_count", 64'(rd_count), 64'(DEPTH));
        check("no_timeout", 64'(timeout_o), 64'd0);
    endtask

    initial begin
        // normal dump
        do_reset(1'b0);
        pulse_finish(50);
        wait_done(1'b1, 1'b0);

        // backpressure with random memory and random finish time
        do_reset(1'b1);
        bp_mode = 1'b1;
        pulse_finish($urandom_range(5, 200));
        wait_done(1'b0, 1'b0);
        bp_mode = 1'b0;

        // watchdog
        do_reset(1'b1);
        while ((cyc - cyc0) < TIMEOUT - 1) @(negedge clk);
        check("timeout_before_expiry", 64'(timeout_o), 64'd0);
        check("halt_before_expiry", 64'(halt_o), 64'd0);
        @(negedge clk);
        check("timeout_at_expiry", 64'(timeout_o), 64'd1);
        check("halt_at_expiry", 64'(halt_o), 64'd1);
        finish_i = 1'b1;
        @(negedge clk);
        finish_i = 1'b0;
        repeat (40) @(negedge clk);
        check("watchdog_no_done", 64'(done_o), 64'd0);
        check("watchdog_no_reads", 64'(rd_count), 64'd0);
        check("watchdog_sticky", 64'(timeout_o), 64'd1);

        // finish on the same edge the watchdog expires
        do_reset(1'b1);
        pulse_finish(TIMEOUT);
        check("simultaneous_no_timeout", 64'(timeout_o), 64'd0);
        wait_done(1'b1, 1'b0);

        // reset while presenting word 100, then restart
        do_reset(1'b1);
        bp_mode = 1'b1;
        pulse_finish(20);
        begin
            int n = 0;
            while (!(out_valid_o && out_index_o == ADDR_W'(100)) && n < 4000) begin
                @(negedge clk);
                n++;
            end
            check("reached_word_100", 64'(out_index_o), 64'd100);
        end
        bp_mode = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_dump_reset_outputs",
              {halt_o, mem_rd_o, out_valid_o, out_last_o, done_o, timeout_o,
               mem_addr_o, out_index_o, out_data_o}, '0);
        exp_q.delete();
        rd_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc0 = cyc;
        pulse_finish(10);
        wait_done(1'b1, 1'b0);

        // finish toggled during the dump and after completion
        do_reset(1'b1);
        pulse_finish(30);
        wait_done(1'b1, 1'b1);
        repeat (60) begin
            @(negedge clk);
            finish_i = $urandom_range(0, 1);
        end
        finish_i = 1'b0;
        @(negedge clk);
        check("done_sticky", 64'(done_o), 64'd1);
        check("no_new_reads", 64'(rd_count), 64'(DEPTH));
        check("halt_held", 64'(halt_o), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
